// File: rtl/sample_framer_if.sv
// Byte stream handshake from the framer to a UART transmitter.
// A transfer happens on a clk edge with tx_valid and tx_ready both high.
interface sample_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/sample_framer.sv
// Snapshots four samples every DIV sample_clk edges and streams CA FE + 8 bytes.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte to each frame.
module sample_framer #(
  parameter int W   = 16,
  parameter int DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic signed [W-1:0] in0,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  sample_framer_if.master     tx,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd4;
`endif

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [2:0]     state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic [4*W-1:0] snap_q, snap_d;
  logic [7:0]     drop_q, drop_d;
  logic [7:0]     div_q, div_d;
  logic           sclk_q, sclk_d;

  logic edge_det;
  logic qual;
  logic xfer;
  logic done;
  logic start;

  // Byte 0 is in0[15:8]; 63 - 8*i is {~i, 3'b111}.
  function automatic logic [7:0] byte_sel(
    input logic [63:0] s,
    input logic [2:0]  i
  );
    return s[{~i, 3'b111} -: 8];
  endfunction

`ifdef FRAME_CHECKSUM_EN
  function automatic logic [7:0] csum(input logic [63:0] s);
    return s[63:56] ^ s[55:48] ^ s[47:40] ^ s[39:32]
         ^ s[31:24] ^ s[23:16] ^ s[15:8]  ^ s[7:0];
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    snap_d   = snap_q;
    drop_d   = drop_q;
    div_d    = div_q;
    sclk_d   = sample_clk;
    done     = 1'b0;
    start    = 1'b0;
    edge_det = sample_clk & ~sclk_q;
    qual     = edge_det && (div_q == 8'd0);
    xfer     = valid_q & tx.tx_ready;

    if (edge_det) begin
      div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: ;
      S_HDR0: begin
        if (xfer) begin
          state_d = S_HDR1;
          data_d  = 8'hFE;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          data_d  = byte_sel(snap_q, 3'd0);
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (idx_q == 3'd7) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = S_CSUM;
            data_d  = csum(snap_q);
`else
            done = 1'b1;
`endif
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = byte_sel(snap_q, idx_q + 3'd1);
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) done = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (done) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      data_d  = 8'h00;
    end

    // A qualifying edge on the final transfer chains straight into a new frame.
    start = qual && ((state_q == S_IDLE) || done);

    if (start) begin
      snap_d  = {in0, in1, in2, in3};
      state_d = S_HDR0;
      valid_d = 1'b1;
      data_d  = 8'hCA;
    end

    if (qual && !start && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      snap_q  <= '0;
      drop_q  <= 8'h00;
      div_q   <= 8'h00;
      sclk_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      snap_q  <= snap_d;
      drop_q  <= drop_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign busy        = (state_q != S_IDLE);
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: frame table plus multi-cycle corner cases.
// Runs a DIV=1 and a DIV=4 instance side by side.
module tb_sample_framer;

`ifdef FRAME_CHECKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sc1 = 1'b0;
  logic sc4 = 1'b0;
  logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic tx_ready;
  logic busy1, busy4;
  logic [7:0] drop1, drop4;
  int rdy_mode = 0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] q1[$];
  logic [7:0] q4[$];

  sample_framer_if if1();
  sample_framer_if if4();
  assign if1.tx_ready = tx_ready;
  assign if4.tx_ready = tx_ready;

  sample_framer #(.W(16), .DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sample_clk(sc1),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .tx(if1), .busy(busy1), .drop_cnt(drop1)
  );

  sample_framer #(.W(16), .DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .sample_clk(sc4),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .tx(if4), .busy(busy4), .drop_cnt(drop4)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Ready pattern: 0 = always, 1 = one cycle on / three off, 2 = held low.
  initial begin
    int ph = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = (ph == 0);
          ph = (ph + 1) % 4;
        end
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Transfer capture and stall-hold checking, sampled mid-cycle.
  logic       st1 = 1'b0;
  logic [7:0] pd1 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      st1 = 1'b0;
    end else begin
      if (st1) begin
        chk("stall_valid", {31'd0, if1.tx_valid}, 32'd1);
        chk("stall_data", {24'd0, if1.tx_data}, {24'd0, pd1});
      end
      if (if1.tx_valid && tx_ready) q1.push_back(if1.tx_data);
      if (if4.tx_valid && tx_ready) q4.push_back(if4.tx_data);
      st1 = if1.tx_valid && !tx_ready;
      pd1 = if1.tx_data;
    end
  end

  function automatic logic [7:0] getb(int which, int idx);
    if (which == 1) return (idx < q1.size()) ? q1[idx] : 8'hxx;
    return (idx < q4.size()) ? q4[idx] : 8'hxx;
  endfunction

  task automatic wait_bytes(int which, int n, int budget);
    while (((which == 1) ? q1.size() : q4.size()) < n && budget > 0) begin
      step();
      budget--;
    end
  endtask

  task automatic cmp_frame(string nm, int which, int base, logic [63:0] exp);
    logic [7:0] cs = 8'h00;
    logic [7:0] eb;
    chk({nm, "_hdr0"}, {24'd0, getb(which, base)}, 32'hCA);
    chk({nm, "_hdr1"}, {24'd0, getb(which, base + 1)}, 32'hFE);
    for (int k = 0; k < 8; k++) begin
      eb = exp[63 - 8*k -: 8];
      cs = cs ^ eb;
      chk($sformatf("%s_d%0d", nm, k), {24'd0, getb(which, base + 2 + k)},
          {24'd0, eb});
    end
`ifdef FRAME_CHECKSUM_EN
    chk({nm, "_csum"}, {24'd0, getb(which, base + 10)}, {24'd0, cs});
`else
    if (cs == 8'hFF) eb = cs;
`endif
  endtask

  typedef struct {
    string       name;
    logic [15:0] a, b, c, d;
    bit          stall;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    int d0;
    vt[0] = '{"basic",  16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 1'b0,
              64'h12_34_FF_FF_80_00_00_01};
    vt[1] = '{"stall",  16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 1'b1,
              64'h12_34_FF_FF_80_00_00_01};
    vt[2] = '{"mixed",  16'hA55A, 16'h0102, 16'hFEDC, 16'h7FFF, 1'b0,
              64'hA5_5A_01_02_FE_DC_7F_FF};
    vt[3] = '{"zeros",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1,
              64'h00_00_00_00_00_00_00_00};

    #1 rst_n = 1'b0;
    step(2);
    chk("rst_valid1", {31'd0, if1.tx_valid}, 32'd0);
    chk("rst_data1", {24'd0, if1.tx_data}, 32'h00);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_drop1", {24'd0, drop1}, 32'd0);
    chk("rst_valid4", {31'd0, if4.tx_valid}, 32'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    rst_n = 1'b1;
    step(3);

    for (int i = 0; i < 4; i++) begin
      rdy_mode = vt[i].stall ? 1 : 0;
      q1.delete();
      {in0, in1, in2, in3} = {vt[i].a, vt[i].b, vt[i].c, vt[i].d};
      sc1 = 1'b1;
      step(2);
      sc1 = 1'b0;
      {in0, in1, in2, in3} = ~{vt[i].a, vt[i].b, vt[i].c, vt[i].d};
      wait_bytes(1, FLEN, 80);
      step(3);
      chk({vt[i].name, "_len"}, q1.size(), FLEN);
      cmp_frame(vt[i].name, 1, 0, vt[i].exp);
      chk({vt[i].name, "_idle"}, {31'd0, busy1}, 32'd0);
    end
    chk("drop_after_table", {24'd0, drop1}, 32'd0);

    // Second edge lands on the final-byte transfer.
    rdy_mode = 0;
    step(2);
    q1.delete();
    d0 = drop1;
    {in0, in1, in2, in3} = 64'h1111_2222_3333_4444;
    sc1 = 1'b1;
    for (int i = 1; i <= FLEN; i++) begin
      step();
      if (i == 2) sc1 = 1'b0;
      if (i == FLEN) begin
        sc1 = 1'b1;
        {in0, in1, in2, in3} = 64'hBEEF_0F0F_C3A5_5A5A;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("chain_valid", {31'd0, if1.tx_valid}, 32'd1);
    chk("chain_data", {24'd0, if1.tx_data}, 32'hCA);
    step();
    sc1 = 1'b0;
    wait_bytes(1, 2*FLEN, 60);
    step(3);
    chk("chain_len", q1.size(), 2*FLEN);
    cmp_frame("chain_a", 1, 0, 64'h1111_2222_3333_4444);
    cmp_frame("chain_b", 1, FLEN, 64'hBEEF_0F0F_C3A5_5A5A);
    chk("chain_drop", {24'd0, drop1}, d0);

    // DIV=4: eight edges 20 cycles apart, edges 1 and 5 qualify.
    q4.delete();
    for (int e = 1; e <= 8; e++) begin
      if (e == 1) {in0, in1, in2, in3} = 64'h0A0B_0C0D_1020_3040;
      else if (e == 5) {in0, in1, in2, in3} = 64'h5566_7788_99AA_BBCC;
      else {in0, in1, in2, in3} = 64'hDEAD_DEAD_DEAD_DEAD;
      sc4 = 1'b1;
      step(2);
      sc4 = 1'b0;
      step(18);
    end
    chk("div4_len", q4.size(), 2*FLEN);
    cmp_frame("div4_f1", 4, 0, 64'h0A_0B_0C_0D_10_20_30_40);
    cmp_frame("div4_f2", 4, FLEN, 64'h55_66_77_88_99_AA_BB_CC);
    chk("div4_drop", {24'd0, drop4}, 32'd0);

    // Overrun: frame stalled while 300 more edges arrive.
    rdy_mode = 2;
    step(3);
    q1.delete();
    {in0, in1, in2, in3} = 64'hCAFE_0123_4567_89AB;
    sc1 = 1'b1;
    step(2);
    sc1 = 1'b0;
    {in0, in1, in2, in3} = 64'h0;
    step(2);
    repeat (100) begin
      sc1 = 1'b1;
      step(2);
      sc1 = 1'b0;
      step(2);
    end
    chk("ovr_drop100", {24'd0, drop1}, 32'd100);
    repeat (200) begin
      sc1 = 1'b1;
      step(2);
      sc1 = 1'b0;
      step(2);
    end
    chk("ovr_drop_sat", {24'd0, drop1}, 32'd255);
    chk("ovr_busy", {31'd0, busy1}, 32'd1);
    chk("ovr_data", {24'd0, if1.tx_data}, 32'hCA);
    chk("ovr_none_sent", q1.size(), 0);
    rdy_mode = 0;
    wait_bytes(1, FLEN, 40);
    step(3);
    chk("ovr_len", q1.size(), FLEN);
    cmp_frame("ovr", 1, 0, 64'hCA_FE_01_23_45_67_89_AB);

    // Reset after the fourth byte with sample_clk high at release.
    q1.delete();
    {in0, in1, in2, in3} = 64'h0F1E_2D3C_4B5A_6978;
    sc1 = 1'b1;
    step(2);
    sc1 = 1'b0;
    wait_bytes(1, 4, 20);
    sc1 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, if1.tx_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy1}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("rstmid_bytes", q1.size(), 4);
    chk("rstmid_noedge", {31'd0, if1.tx_valid}, 32'd0);
    chk("rstmid_drop", {24'd0, drop1}, 32'd0);
    sc1 = 1'b0;
    step(2);
    q1.delete();
    {in0, in1, in2, in3} = 64'h7654_3210_FEDC_BA98;
    sc1 = 1'b1;
    step(2);
    sc1 = 1'b0;
    wait_bytes(1, FLEN, 40);
    step(3);
    chk("post_rst_len", q1.size(), FLEN);
    cmp_frame("post_rst", 1, 0, 64'h76_54_32_10_FE_DC_BA_98);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
